// File: rtl/fnd_scan_controller_if.sv
// Handshake/display bundle between the FND scan controller and its driver.
// The DUT side uses the slave modport.
interface fnd_scan_controller_if;
  logic [13:0] i_value;
  logic        i_load;
  logic        i_blank;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_value;
  logic        o_en;
  logic        o_busy;
  logic        o_ovf;

  modport master (
    output i_value, i_load, i_blank,
    input  o_digitSelect, o_value, o_en, o_busy, o_ovf
  );

  modport slave (
    input  i_value, i_load, i_blank,
    output o_digitSelect, o_value, o_en, o_busy, o_ovf
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD (double-dabble) converter with a 4-digit time-multiplexed
// scan output feeding the downstream BCD-to-FND decode stage.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  fnd_scan_controller_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [13:0] VALUE_MAX = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    shift_cnt_r;
  logic [29:0]   dd_r;
  logic [29:0]   dd_shift_s;
  logic [15:0]   disp_r;
  logic          ovf_r;
  logic          busy_r;
  logic [PW-1:0] pre_r;
  logic [1:0]    slot_r;
  logic [3:0]    lz_s;
  logic [3:0]    digit_s;
  logic [1:0]    sel_r;
  logic [3:0]    val_r;
  logic          en_r;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    add3 = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  function automatic logic [15:0] add3_all(input logic [15:0] bcd);
    add3_all = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  endfunction

  // converter next-state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_load) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_cnt_r == 4'd13) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  assign dd_shift_s = {add3_all(dd_r[29:14]), dd_r[13:0]} << 1;

  // converter state and datapath; display is written only on COMMIT
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      shift_cnt_r <= 4'd0;
      dd_r        <= 30'd0;
      disp_r      <= 16'd0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (bus.i_load) begin
            dd_r        <= {16'd0, (bus.i_value > VALUE_MAX) ? VALUE_MAX : bus.i_value};
            ovf_r       <= (bus.i_value > VALUE_MAX);
            shift_cnt_r <= 4'd0;
          end
        end
        ST_SHIFT: begin
          dd_r        <= dd_shift_s;
          shift_cnt_r <= shift_cnt_r + 4'd1;
        end
        ST_COMMIT: disp_r <= dd_r[29:14];
        default: begin
          dd_r        <= 30'd0;
          shift_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // free-running prescaler and digit slot
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pre_r  <= '0;
      slot_r <= 2'd0;
    end else if (pre_r == PRE_LAST) begin
      pre_r  <= '0;
      slot_r <= slot_r + 2'd1;
    end else begin
      pre_r  <= pre_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // leading-zero flags: digit k blanks when it and all higher digits are 0
  always_comb begin
    lz_s = 4'b0000;
    if (LZ_BLANK) begin
      lz_s[3] = (disp_r[15:12] == 4'd0);
      lz_s[2] = lz_s[3] & (disp_r[11:8] == 4'd0);
      lz_s[1] = lz_s[2] & (disp_r[7:4] == 4'd0);
      lz_s[0] = 1'b0;
    end else begin
      lz_s = 4'b0000;
    end
  end

  always_comb begin
    digit_s = 4'd0;
    case (slot_r)
      2'd0:    digit_s = disp_r[3:0];
      2'd1:    digit_s = disp_r[7:4];
      2'd2:    digit_s = disp_r[11:8];
      2'd3:    digit_s = disp_r[15:12];
      default: digit_s = 4'd0;
    endcase
  end

  // registered scan outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sel_r <= 2'd0;
      val_r <= 4'd0;
      en_r  <= 1'b0;
    end else begin
      sel_r <= slot_r;
      val_r <= digit_s;
      en_r  <= ~bus.i_blank & ~lz_s[slot_r];
    end
  end

  assign bus.o_digitSelect = sel_r;
  assign bus.o_value       = val_r;
  assign bus.o_en          = en_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_ovf         = ovf_r;

endmodule
